// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal chunks, one chunk resolved per
// register stage, with upper operand bits travelling alongside until their chunk is reached.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage k registers: bits below (k+1)*CW of acc_q are final; a_q/b_q keep the (effective) operands.
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] src_acc [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic             src_c   [STAGES];
  logic             src_v   [STAGES];
  logic [WIDTH-1:0] acc_d   [STAGES];
  logic             c_d     [STAGES];
  logic             ovf_d;
  logic             advance;

  // Handshake: a side transfers on a rising edge where its valid && ready are both 1; the whole
  // pipe moves when the output slot is empty or being taken, so in_ready never looks at in_valid.
  assign advance   = !v_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign sum       = acc_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  always_comb begin
    logic x, y, c;
    src_acc[0] = '0;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = sub | cin;
    src_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_acc[k] = acc_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = c_q[k-1];
      src_v[k]   = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      acc_d[k] = src_acc[k];
      c = src_c[k];
      for (int i = 0; i < CW; i++) begin
        x = src_a[k][k*CW + i];
        y = src_b[k][k*CW + i];
        acc_d[k][k*CW + i] = x ^ y ^ c;
        c = (c & (x ^ y)) | (x & y);
      end
      c_d[k] = c;
    end
    ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
            (acc_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
  end

  // Bubbles move the valid bit only, so an idle output keeps its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        acc_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          acc_q[k] <= acc_d[k];
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (src_v[LAST]) ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases, backpressure, mid-stream reset and a random
// stream, all scored against an arithmetic model of a +/- b.
module tb_pipelined_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int NRAND  = 2000;
  localparam longint MAXS = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, sub, cout, ovf;

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic             stalled = 1'b0;
  logic [WIDTH+1:0] held;
  logic             done_rand;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference: {ovf, cout, sum} from integer arithmetic on the operands
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] av, bv, input logic cv, sv);
    longint unsigned ua, ub, full;
    longint sa, sb, ideal;
    logic c, o;
    ua = av;
    ub = bv;
    sa = $signed(av);
    sb = $signed(bv);
    if (sv) begin
      full  = ua - ub;
      c     = (ua >= ub);
      ideal = sa - sb;
    end else begin
      full  = ua + ub + longint'(cv);
      c     = full[WIDTH];
      ideal = sa + sb + longint'(cv);
    end
    o = (ideal > MAXS) || (ideal < MINS);
    return {o, c, full[WIDTH-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: inputs pushed on transfer, results popped and compared on transfer
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (in_ready === (!out_valid || out_ready)) else begin
        errors++;
        $error("FAIL in_ready_rule: observed %b expected %b", in_ready, !out_valid || out_ready);
      end
      if (stalled) begin
        checks++;
        assert ({out_valid, ovf, cout, sum} === {1'b1, held}) else begin
          errors++;
          $error("FAIL stall_hold: observed %0h expected %0h", {out_valid, ovf, cout, sum}, {1'b1, held});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed output %0h expected no output", sum);
        end
        if (exp_q.size() != 0) begin
          logic [WIDTH+1:0] e;
          e = exp_q.pop_front();
          checks++;
          assert ({ovf, cout, sum} === e) else begin
            errors++;
            $error("FAIL sb_result: observed ovf/cout/sum %0h expected %0h", {ovf, cout, sum}, e);
          end
        end
        delivered++;
      end
      stalled = out_valid && !out_ready;
      held    = {ovf, cout, sum};
    end else begin
      stalled = 1'b0;
    end
  end

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send(input logic [WIDTH-1:0] av, bv, input logic cv, sv);
    int n = 0;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [WIDTH-1:0] av, bv, input logic cv, sv,
                         input logic [WIDTH-1:0] es, input logic ec, eo);
    int lat = 1;
    send(av, bv, cv, sv);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, STAGES);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int d0, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout_ovf", {cout, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // backpressure: 8 back-to-back ops, output held for 5 cycles after the first result
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        held = {ovf, cout, sum};
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_hold", {out_valid, ovf, cout, sum}, {1'b1, held});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", delivered - d0, 8);

    // reset with three ops in flight
    run_one("pre_rst", 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_emerge", seen, 0);
    @(posedge clk);
    #1;

    // random stream with random idle input and random output backpressure
    d0 = delivered;
    done_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand");
    check("rand_count", delivered - d0, NRAND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
